// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - width and index helpers shared by the host arbiter and its tracking FIFO
package bus_arb_pkg;

    // Index width for n entries; a single entry still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // (base + off) mod n, valid for base < n and off <= n.
    function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// rtl/bus_arb_id_fifo.sv - in-order FIFO of host indices for outstanding transactions
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);
    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = cnt_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// rtl/bus_host_arbiter.sv - round-robin OBI host arbiter with in-order response routing
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NrHosts-1:0]      host_req_i,
    output logic [NrHosts-1:0]      host_gnt_o,
    input  logic [AddressWidth-1:0] host_addr_i   [NrHosts],
    input  logic [NrHosts-1:0]      host_we_i,
    input  logic [DataWidth/8-1:0]  host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i  [NrHosts],
    output logic [NrHosts-1:0]      host_rvalid_o,
    output logic [DataWidth-1:0]    host_rdata_o  [NrHosts],
    output logic [NrHosts-1:0]      host_err_o,
    output logic                    dev_req_o,
    output logic [AddressWidth-1:0] dev_addr_o,
    output logic                    dev_we_o,
    output logic [DataWidth/8-1:0]  dev_be_o,
    output logic [DataWidth-1:0]    dev_wdata_o,
    input  logic                    dev_gnt_i,
    input  logic                    dev_rvalid_i,
    input  logic [DataWidth-1:0]    dev_rdata_i,
    input  logic                    dev_err_i
);
    localparam int unsigned IdxW = idx_width(NrHosts);
    typedef logic [IdxW-1:0] host_idx_t;

    host_idx_t prio_q, prio_d, lock_idx_q, lock_idx_d;
    host_idx_t rr_sel, cand, sel, fifo_head;
    logic      lock_q, lock_d;
    logic      rr_found, can_issue, accept, rsp_valid;
    logic      fifo_full, fifo_empty;

    always_comb begin
        rr_sel   = prio_q;
        rr_found = 1'b0;
        cand     = prio_q;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            cand = host_idx_t'(wrap_add(32'(prio_q), i, NrHosts));
            if (!rr_found && host_req_i[cand]) begin
                rr_sel   = cand;
                rr_found = 1'b1;
            end
        end
    end

    // A stalled request keeps its host selected so the downstream payload stays stable.
    assign sel        = lock_q ? lock_idx_q : rr_sel;
    assign can_issue  = !fifo_full || dev_rvalid_i;
    assign dev_req_o  = rst_ni && host_req_i[sel] && can_issue;
    assign accept     = dev_req_o && dev_gnt_i;
    assign rsp_valid  = dev_rvalid_i && !fifo_empty;

    assign dev_addr_o  = host_addr_i[sel];
    assign dev_we_o    = host_we_i[sel];
    assign dev_be_o    = host_be_i[sel];
    assign dev_wdata_o = host_wdata_i[sel];

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            host_gnt_o[i]    = accept && (sel == host_idx_t'(i));
            host_rvalid_o[i] = rsp_valid && (fifo_head == host_idx_t'(i));
            host_err_o[i]    = rsp_valid && (fifo_head == host_idx_t'(i)) && dev_err_i;
            host_rdata_o[i]  = dev_rdata_i;
        end
    end

    always_comb begin
        prio_d     = prio_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            prio_d = host_idx_t'(wrap_add(32'(sel), 1, NrHosts));
            lock_d = 1'b0;
        end else if (dev_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (sel),
        .pop_i   (dev_rvalid_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // A response with nothing outstanding is a downstream protocol error.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(dev_rvalid_i && fifo_empty));

endmodule
